// File: rtl/fmlarb_pkg.sv
// Shared definitions for the four-port FML round-robin arbiter: state
// encoding, port count and a one-hot to index helper.
package fmlarb_pkg;

    localparam int NPORTS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    function automatic logic [1:0] onehot2idx(input logic [NPORTS-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fmlarb_rr_pick.sv
// Combinational 4-way round-robin picker: first requester at or above ptr_i,
// wrapping from 3 back to 0.
module fmlarb_rr_pick
    import fmlarb_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [1:0] gnt_o,
    output logic       valid_o
);

    logic [3:0] rot;
    logic [3:0] first_oh;

    // Rotate so the pointer position lands on bit 0, isolate the lowest set
    // bit, then rotate the index back.
    always_comb begin
        rot = '0;
        for (int j = 0; j < NPORTS; j++) begin
            rot[j] = req_i[2'(j) + ptr_i];
        end
        first_oh = rot & (~rot + 4'd1);
        gnt_o    = onehot2idx(first_oh) + ptr_i;
        valid_o  = |req_i;
    end

endmodule

// File: rtl/fmlarb_rr.sv
// Round-robin arbiter sharing one FML slave among four FML masters.
// Optional parking of the last owner is enabled by defining FMLARB_PARK_EN.
module fmlarb_rr
    import fmlarb_pkg::*;
#(
    parameter int fml_depth = 25,
    parameter int burst_len = 4
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [4*fml_depth-1:0] m_adr,
    input  logic [3:0]             m_stb,
    input  logic [3:0]             m_we,
    input  logic [15:0]            m_sel,
    input  logic [127:0]           m_do,
    output logic [3:0]             m_ack,
    output logic [31:0]            m_di,
    output logic [fml_depth-1:0]   fml_adr,
    output logic                   fml_stb,
    output logic                   fml_we,
    input  logic                   fml_ack,
    output logic [3:0]             fml_sel,
    output logic [31:0]            fml_do,
    input  logic [31:0]            fml_di
);

    localparam logic [2:0] BEAT_LAST = 3'(burst_len - 1);

    state_t               state_q;
    logic [1:0]           owner_q;
    logic                 own_vld_q;
    logic [1:0]           ptr_q;
    logic [2:0]           cnt_q;

    logic [1:0]           pick_gnt;
    logic                 pick_vld;
    logic [fml_depth-1:0] own_adr;
    logic                 own_stb;
    logic                 own_we;
    logic [3:0]           own_sel;
    logic [31:0]          own_do;
    logic                 park_hit;
    logic                 addr_ph;

    fmlarb_rr_pick u_pick (
        .req_i   (m_stb),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_vld)
    );

    always_comb begin
        own_adr = m_adr[int'(owner_q)*fml_depth +: fml_depth];
        own_stb = m_stb[owner_q];
        own_we  = m_we[owner_q];
        own_sel = m_sel[int'(owner_q)*4 +: 4];
        own_do  = m_do[int'(owner_q)*32 +: 32];
    end

    // A parked owner requesting alone skips arbitration and is treated as
    // being in its address phase this very cycle.
`ifdef FMLARB_PARK_EN
    assign park_hit = (state_q == IDLE) && own_vld_q && (m_stb == (4'b0001 << owner_q));
`else
    assign park_hit = 1'b0;
`endif

    assign addr_ph = (state_q == ADDR) || park_hit;
    assign m_di    = fml_di;

    always_comb begin
        fml_stb = addr_ph & own_stb;
        fml_adr = own_vld_q ? own_adr : '0;
        fml_we  = own_vld_q & own_we;
        fml_sel = own_vld_q ? own_sel : '0;
        fml_do  = own_vld_q ? own_do : '0;
        m_ack   = '0;
        if (addr_ph) m_ack[owner_q] = fml_ack;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            own_vld_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (park_hit) begin
                        if (fml_ack) begin
                            state_q <= DATA;
                            cnt_q   <= BEAT_LAST;
                            ptr_q   <= owner_q + 2'd1;
                        end else begin
                            state_q <= ADDR;
                        end
                    end else if (pick_vld) begin
                        owner_q   <= pick_gnt;
                        own_vld_q <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (fml_ack) begin
                        state_q <= DATA;
                        cnt_q   <= BEAT_LAST;
                        ptr_q   <= owner_q + 2'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= IDLE;
`ifdef FMLARB_PARK_EN
                        own_vld_q <= 1'b1;
`else
                        own_vld_q <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fmlarb_rr.sv
// Self-checking bench for fmlarb_rr: scoreboard of expected grants checked on
// every master ack, plus per-scenario inline checks.
module tb_fmlarb_rr;

    localparam int FD = 25;
    localparam int BL = 4;
`ifdef FMLARB_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    typedef struct {
        int          idx;
        logic [FD-1:0] adr;
        logic        we;
    } exp_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [4*FD-1:0] m_adr;
    logic [3:0]    m_stb;
    logic [3:0]    m_we;
    logic [15:0]   m_sel;
    logic [127:0]  m_do;
    logic [3:0]    m_ack;
    logic [31:0]   m_di;
    logic [FD-1:0] fml_adr;
    logic          fml_stb;
    logic          fml_we;
    logic          fml_ack;
    logic [3:0]    fml_sel;
    logic [31:0]   fml_do;
    logic [31:0]   fml_di;

    int   checks = 0;
    int   errors = 0;
    int   lat = 2;
    int   wcnt = 0;
    exp_t sb[$];
    logic [3:0] prev_ack = '0;

    fmlarb_rr #(.fml_depth(FD), .burst_len(BL)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .m_adr   (m_adr),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_sel   (m_sel),
        .m_do    (m_do),
        .m_ack   (m_ack),
        .m_di    (m_di),
        .fml_adr (fml_adr),
        .fml_stb (fml_stb),
        .fml_we  (fml_we),
        .fml_ack (fml_ack),
        .fml_sel (fml_sel),
        .fml_do  (fml_do),
        .fml_di  (fml_di)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [FD-1:0] adr_of(input int i);
        return 25'h000100 + 25'(i) * 25'h10000;
    endfunction

    function automatic exp_t mk(input int i, input logic we);
        exp_t e;
        e.idx = i;
        e.adr = adr_of(i);
        e.we  = we;
        return e;
    endfunction

    // Slave model: ack lat cycles after strobe, one-cycle ack.
    initial begin
        fml_ack = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (fml_ack) begin
                fml_ack = 1'b0;
                wcnt = 0;
            end else if (fml_stb) begin
                wcnt++;
                if (wcnt >= lat) fml_ack = 1'b1;
            end else begin
                wcnt = 0;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!sys_rst) begin
                checks++;
                if (!$onehot0(m_ack)) begin
                    errors++;
                    $display("FAIL ack_onehot m_ack=%b required at most one bit", m_ack);
                end
                if (m_ack != 4'b0) begin
                    int idx;
                    idx = 0;
                    for (int i = 0; i < 4; i++) if (m_ack[i]) idx = i;
                    checks++;
                    if ((m_ack & prev_ack) != 4'b0) begin
                        errors++;
                        $display("FAIL ack_pulse m_ack=%b prev=%b required single-cycle", m_ack, prev_ack);
                    end
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_ack m_ack=%b required no ack", m_ack);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        checks++;
                        if (idx !== e.idx || fml_adr !== e.adr || fml_we !== e.we || fml_stb !== 1'b1) begin
                            errors++;
                            $display("FAIL grant got m=%0d adr=%h we=%b stb=%b required m=%0d adr=%h we=%b stb=1",
                                     idx, fml_adr, fml_we, fml_stb, e.idx, e.adr, e.we);
                        end
                    end
                end
                prev_ack = m_ack;
            end else begin
                prev_ack = '0;
            end
        end
    end

    task automatic wait_ack(input int m, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!m_ack[m] && n < 100);
        checks++;
        if (!m_ack[m]) begin
            errors++;
            $display("FAIL %s_timeout m_ack=%b required bit %0d", nm, m_ack, m);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        m_stb = '0; m_we = '0; m_sel = '0; m_do = '0; fml_di = '0;
        for (int i = 0; i < 4; i++) m_adr[i*FD +: FD] = adr_of(i);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        checks++;
        if (fml_stb !== 1'b0 || m_ack !== 4'b0 || fml_adr !== '0 || fml_we !== 1'b0 ||
            fml_sel !== 4'b0 || fml_do !== 32'b0) begin
            errors++;
            $display("FAIL reset_outputs stb=%b ack=%b adr=%h we=%b sel=%h do=%h required all zero",
                     fml_stb, m_ack, fml_adr, fml_we, fml_sel, fml_do);
        end
        checks++;
        if (dut.state_q !== 2'd0 || dut.ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL reset_state state=%0d ptr=%0d required 0 0", dut.state_q, dut.ptr_q);
        end
        sys_rst = 1'b0;
    endtask

    task automatic test_all_four();
        int n;
        sb.push_back(mk(0, 1'b0));
        sb.push_back(mk(1, 1'b0));
        sb.push_back(mk(2, 1'b0));
        sb.push_back(mk(3, 1'b0));
        sb.push_back(mk(0, 1'b0));
        @(negedge sys_clk);
        m_stb = 4'hF;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL all_four_grants pending=%0d required 0", sb.size());
        end
        @(posedge sys_clk);
        #2;
        m_stb = '0;
        repeat (BL + 2) @(negedge sys_clk);
    endtask

    task automatic test_single();
        sb.push_back(mk(0, 1'b0));
        m_stb = 4'b0001;
        wait_ack(0, "single");
        checks++;
        if (fml_adr !== 25'h000100) begin
            errors++;
            $display("FAIL single_adr got %h required 000100", fml_adr);
        end
        @(posedge sys_clk);
        #2;
        m_stb = '0;
        for (int i = 0; i < BL; i++) begin
            @(negedge sys_clk);
            checks++;
            if (fml_stb !== 1'b0 || dut.state_q !== 2'd2) begin
                errors++;
                $display("FAIL single_data beat=%0d stb=%b state=%0d required 0 2", i, fml_stb, dut.state_q);
            end
        end
        @(negedge sys_clk);
        checks++;
        if (dut.state_q !== 2'd0 || fml_stb !== 1'b0) begin
            errors++;
            $display("FAIL single_idle state=%0d stb=%b required 0 0", dut.state_q, fml_stb);
        end
    endtask

    task automatic test_write();
        m_we[2] = 1'b1;
        m_do[64 +: 32] = 32'hDEADBEEF;
        m_sel[8 +: 4] = 4'hF;
        sb.push_back(mk(2, 1'b1));
        m_stb = 4'b0100;
        wait_ack(2, "write");
        checks++;
        if (fml_do !== 32'hDEADBEEF || fml_sel !== 4'hF) begin
            errors++;
            $display("FAIL write_ack_data do=%h sel=%h required deadbeef f", fml_do, fml_sel);
        end
        @(posedge sys_clk);
        #2;
        m_stb = '0;
        for (int i = 0; i < BL; i++) begin
            @(negedge sys_clk);
            checks++;
            if (fml_do !== 32'hDEADBEEF || fml_sel !== 4'hF || dut.state_q !== 2'd2) begin
                errors++;
                $display("FAIL write_beat beat=%0d do=%h sel=%h state=%0d required deadbeef f 2",
                         i, fml_do, fml_sel, dut.state_q);
            end
        end
        @(negedge sys_clk);
        m_we = '0;
    endtask

    task automatic test_holdoff();
        sb.push_back(mk(3, 1'b0));
        sb.push_back(mk(1, 1'b0));
        m_stb = 4'b1000;
        wait_ack(3, "holdoff_m3");
        @(posedge sys_clk);
        #2;
        m_stb = 4'b0010;
        for (int i = 0; i < BL; i++) begin
            @(negedge sys_clk);
            checks++;
            if (m_ack !== 4'b0 || dut.state_q !== 2'd2) begin
                errors++;
                $display("FAIL holdoff_data beat=%0d ack=%b state=%0d required 0000 2", i, m_ack, dut.state_q);
            end
        end
        wait_ack(1, "holdoff_m1");
        @(posedge sys_clk);
        #2;
        m_stb = '0;
        @(negedge sys_clk);
        checks++;
        if (dut.ptr_q !== 2'd2) begin
            errors++;
            $display("FAIL holdoff_ptr got %0d required 2", dut.ptr_q);
        end
        repeat (BL) @(negedge sys_clk);
    endtask

    task automatic test_rst_mid();
        sb.push_back(mk(0, 1'b0));
        m_stb = 4'b0001;
        wait_ack(0, "rst_mid");
        @(posedge sys_clk);
        #2;
        m_stb = '0;
        @(posedge sys_clk);
        #2;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #2;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (dut.state_q !== 2'd0 || fml_stb !== 1'b0 || m_ack !== 4'b0 || dut.ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid state=%0d stb=%b ack=%b ptr=%0d required 0 0 0000 0",
                     dut.state_q, fml_stb, m_ack, dut.ptr_q);
        end
        sb.push_back(mk(1, 1'b0));
        sb.push_back(mk(3, 1'b0));
        m_stb = 4'b1010;
        wait_ack(1, "rst_m1");
        @(posedge sys_clk);
        #2;
        m_stb[1] = 1'b0;
        wait_ack(3, "rst_m3");
        @(posedge sys_clk);
        #2;
        m_stb = '0;
        repeat (BL + 1) @(negedge sys_clk);
    endtask

    task automatic test_back_to_back();
        sb.push_back(mk(0, 1'b0));
        sb.push_back(mk(0, 1'b0));
        sb.push_back(mk(2, 1'b0));
        sb.push_back(mk(0, 1'b0));
        m_stb = 4'b0001;
        wait_ack(0, "b2b_first");
        repeat (BL) @(negedge sys_clk);
        @(negedge sys_clk);
        checks++;
        if (fml_stb !== PARK) begin
            errors++;
            $display("FAIL b2b_bubble stb=%b required %b", fml_stb, PARK);
        end
        wait_ack(0, "b2b_second");
        @(posedge sys_clk);
        #2;
        m_stb = 4'b0101;
        repeat (BL) @(negedge sys_clk);
        @(negedge sys_clk);
        checks++;
        if (fml_stb !== 1'b0 || m_ack !== 4'b0) begin
            errors++;
            $display("FAIL b2b_contend stb=%b ack=%b required 0 0000", fml_stb, m_ack);
        end
        wait_ack(2, "b2b_m2");
        @(posedge sys_clk);
        #2;
        m_stb[2] = 1'b0;
        wait_ack(0, "b2b_m0");
        @(posedge sys_clk);
        #2;
        m_stb = '0;
        repeat (BL + 1) @(negedge sys_clk);
    endtask

    task automatic test_mdi();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] v;
            v = $urandom;
            fml_di = v;
            #1;
            checks++;
            if (m_di !== v) begin
                errors++;
                $display("FAIL mdi got %h required %h", m_di, v);
            end
            @(negedge sys_clk);
        end
    endtask

    initial begin
        test_reset();
        test_all_four();
        test_single();
        test_write();
        test_holdoff();
        test_rst_mid();
        test_back_to_back();
        test_mdi();
        repeat (5) @(negedge sys_clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fmlarb_rr.md
Name: fmlarb_rr

Overview:
- Round-robin arbiter that shares one FML slave port (the memory controller side) between four FML masters, e.g. the CPU bridge, video framebuffer, texture mapper and DMA.
- Each master sees a complete FML port. The arbiter locks the slave to one master for that master's address phase and the following burst data phase.
- It then re-arbitrates fairly among the masters.

Parameters:
- fml_depth, 25, FML address width in bits.
- burst_len, 4, data beats per FML transaction after ack (range 2..8).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- m_adr  in  4*fml_depth  master addresses; master i occupies slice [i*fml_depth +: fml_depth].
- m_stb  in  4  per-master strobe, held by the master until its ack.
- m_we  in  4  per-master write enable.
- m_sel  in  16  per-master byte enables, 4 bits per master.
- m_do  in  128  per-master write data, 32 bits per master.
- m_ack  out  4  per-master ack.
- m_di  out  32  read data, broadcast to all masters.
- fml_adr  out  fml_depth  slave address.
- fml_stb  out  1  slave strobe.
- fml_we  out  1  slave write enable.
- fml_ack  in  1  slave ack.
- fml_sel  out  4  slave byte enables.
- fml_do  out  32  slave write data.
- fml_di  in  32  slave read data.

Behaviour:
- Reset:
  - state=IDLE, owner=none, rr pointer=0 (master 0 has highest priority first).
  - fml_stb=0, m_ack=0, beat counter=0.
  - fml_adr/fml_we/fml_sel/fml_do=0 while owner=none.
- States: IDLE, ADDR, DATA.
- IDLE:
  - If any m_stb is set, select the first requester scanning from rr pointer upward with wrap (3 wraps to 0).
  - Register it as owner and go to ADDR.
  - Arbitration costs one cycle; fml_stb stays 0 in IDLE.
- ADDR:
  - Drive fml_stb=m_stb[owner], fml_adr=m_adr[owner], fml_we=m_we[owner], combinationally from the owner's slice.
  - Drive m_ack[owner]=fml_ack combinationally; all other m_ack=0.
  - When fml_ack=1: go to DATA, load beat counter=burst_len-1, and set rr pointer=owner+1 (mod 4).
- DATA:
  - fml_stb=0. fml_sel and fml_do are muxed from the owner for every DATA cycle.
  - Each cycle the counter decrements.
  - At counter=0: go to IDLE, owner=none.
  - DATA therefore lasts exactly burst_len cycles after the ack cycle.
- m_di=fml_di in all states, unregistered. Masters qualify read data with their own ack timing.
- Owner dropping m_stb in ADDR before ack is a protocol violation. The arbiter keeps the owner and waits for ack; no recovery is needed.
- Simultaneous requests: resolved strictly by rr pointer, so no master waits more than 3 transactions.
- A new m_stb arriving during ADDR/DATA is held off (m_ack=0) until the next IDLE.
- sys_rst asserted mid-transaction: state returns to IDLE immediately on that edge, any burst in flight is abandoned, and the pointer is reset to 0.
- Maximum back-to-back throughput: one transaction per burst_len+2 cycles (without the optional feature), plus the slave's ack latency.

Optional Feature:
- Macro: FMLARB_PARK_EN.
- Defined:
  - At DATA end the owner is kept ("parked") and the arbiter enters IDLE-parked.
  - If the parked master asserts m_stb while no other master requests, the arbiter moves to ADDR in the same cycle, with fml_stb driven combinationally. This gives zero arbitration latency.
  - If any other master requests, normal round-robin arbitration applies (one cycle).
  - Reset clears parking.
- Not defined: owner=none after every DATA and the one-cycle IDLE always applies.

Decomposition:
- Shared package fmlarb_pkg:
  - state encoding constants (IDLE=2'd0, ADDR=2'd1, DATA=2'd2);
  - NPORTS=4;
  - a one-hot-to-index conversion function.
- One natural sub-module: fmlarb_rr_pick.
  - Combinational 4-way round-robin priority picker.
  - Inputs: req[3:0], ptr[1:0]. Outputs: gnt index [1:0], valid.
  - Verified exhaustively on its own.

Test Plan:
- Single master: m_stb=4'b0001, adr=0x000100, slave acks 2 cycles after fml_stb -> fml_adr=0x000100, m_ack[0] pulses for 1 cycle, fml_stb low for 4 DATA cycles, then IDLE.
- All four masters request continuously -> grant order 0,1,2,3,0; each m_ack is a single-cycle pulse; no two m_ack bits are set together.
- Write burst from master 2 with m_do slice=0xDEADBEEF, sel=4'hF -> fml_do=0xDEADBEEF and fml_sel=4'hF for the ack cycle plus 4 DATA cycles; fml_we=1 in ADDR.
- Master 1 requests during master 3's DATA phase -> m_ack[1] stays 0 until master 3's DATA ends; master 1 is granted next; the pointer becomes 2 after its ack.
- sys_rst pulsed on DATA beat 2 -> next cycle state=IDLE, fml_stb=0, all m_ack=0; m_stb=4'b1010 then grants master 1 first.
- FMLARB_PARK_EN: master 0 issues back-to-back requests alone -> second fml_stb asserts in the cycle after DATA ends (no IDLE bubble); if master 2 requests concurrently, the bubble returns and master 2 is granted.
